// File: rtl/and_tree_pipe.sv
// Pipelined masked AND/NAND reduction over CHANNELS independent WIDTH-bit operands,
// with a valid/ready handshake on both sides and bubble-collapsing backpressure.
module and_tree_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PIPE     = 2
) (
  input  logic                      CLK,
  input  logic                      R,
  input  logic [CHANNELS*WIDTH-1:0] A,
  input  logic [CHANNELS*WIDTH-1:0] M,
  input  logic                      MODE,
  input  logic                      IV,
  output logic                      IR,
  output logic [CHANNELS-1:0]       Y,
  output logic                      OV,
  input  logic                      OR_
);

  logic [CHANNELS-1:0] red;
  logic [PIPE-1:0]     adv;
  logic [PIPE-1:0]     vld_q;
  logic [CHANNELS-1:0] dat_q  [PIPE];
  logic                up_vld [PIPE];
  logic [CHANNELS-1:0] up_dat [PIPE];

  // Masked inputs are forced to 1, so a fully masked channel reduces to all-ones.
  always_comb begin
    red = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      red[c] = (&(A[c*WIDTH +: WIDTH] | ~M[c*WIDTH +: WIDTH])) ^ MODE;
    end
  end

  // A stage may advance unless it and every stage downstream of it is full while
  // the consumer stalls; computed from the tail so there is no ripple through adv.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = int'(PIPE) - 1; k >= 0; k--) begin
      full   = full & vld_q[k];
      adv[k] = OR_ | ~full;
    end
  end

  always_comb begin
    up_vld[0] = IV;
    up_dat[0] = red;
    for (int k = 1; k < int'(PIPE); k++) begin
      up_vld[k] = vld_q[k-1];
      up_dat[k] = dat_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      vld_q <= '0;
      for (int k = 0; k < int'(PIPE); k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(PIPE); k++) begin
        if (adv[k]) begin
          vld_q[k] <= up_vld[k];
          if (up_vld[k]) begin
            dat_q[k] <= up_dat[k];
          end
        end
      end
    end
  end

  assign IR = adv[0];
  assign OV = vld_q[PIPE-1];
  assign Y  = dat_q[PIPE-1];

endmodule
